// File: rtl/ofdm_framer_pkg.sv
// Shared definitions for the OFDM cyclic-prefix framer.
// Holds the framer state enum, the settings-register offsets relative to the
// settings-bus base address, and the power-up values of the shadow settings.
package ofdm_framer_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StOffset,
    StFrame,
    StGap
  } state_e;

  // Register offsets from SR_BASE.
  localparam int unsigned SR_FRAME_LEN  = 0;
  localparam int unsigned SR_GAP_LEN    = 1;
  localparam int unsigned SR_OFFSET     = 2;
  localparam int unsigned SR_MAX_FRAMES = 3;

  // Shadow register values after reset.
  localparam logic [15:0] RstFrameLen = 16'd64;
  localparam logic [15:0] RstGapLen   = 16'd16;
  localparam logic [15:0] RstOffset   = 16'd0;
  localparam logic [15:0] RstMaxFrame = 16'd1;

endpackage

// File: rtl/ofdm_cp_framer_if.sv
// Stream interface of the OFDM cyclic-prefix framer.
// Carries the input AXI-stream (i_*, with i_ttrig sideband) and the output
// AXI-stream (o_*). The slave modport is the framer's view; the master modport
// is the view of the environment that feeds and drains it.
interface ofdm_cp_framer_if #(
  parameter int unsigned WIDTH = 32
) ();

  logic [WIDTH-1:0] i_tdata;
  logic             i_ttrig;
  logic             i_tlast;
  logic             i_tvalid;
  logic             i_tready;

  logic [WIDTH-1:0] o_tdata;
  logic             o_tlast;
  logic             o_tvalid;
  logic             o_tready;

  modport master (
    output i_tdata, i_ttrig, i_tlast, i_tvalid,
    input  i_tready,
    input  o_tdata, o_tlast, o_tvalid,
    output o_tready
  );

  modport slave (
    input  i_tdata, i_ttrig, i_tlast, i_tvalid,
    output i_tready,
    output o_tdata, o_tlast, o_tvalid,
    input  o_tready
  );

endinterface

// File: rtl/setting_reg.sv
// Single settings-bus register.
// Captures the low Width bits of the settings data when the strobe is high and
// the address matches MyAddr; holds AtReset after a synchronous reset.
// Ports: clk_i, rst_i (sync, active-high), strobe_i, addr_i[7:0], in_i[31:0],
//        out_o[Width-1:0] (current register value).
module setting_reg #(
  parameter int unsigned      Width   = 16,
  parameter logic [7:0]       MyAddr  = 8'd0,
  parameter logic [Width-1:0] AtReset = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             strobe_i,
  input  logic [7:0]       addr_i,
  input  logic [31:0]      in_i,
  output logic [Width-1:0] out_o
);

  logic [Width-1:0] out_d, out_q;

  always_comb begin
    out_d = out_q;
    if (strobe_i && (addr_i == MyAddr)) begin
      out_d = in_i[Width-1:0];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_q <= AtReset;
    end else begin
      out_q <= out_d;
    end
  end

  assign out_o = out_q;

  // Upper data bits are ignored when Width < 32.
  logic unused_in;
  assign unused_in = ^in_i;

endmodule

// File: rtl/ofdm_cp_framer.sv
// OFDM cyclic-prefix framer.
// Waits for a trigger sample, drops `offset` samples, then passes frames of
// frame_len samples separated by gap_len dropped samples, max_frames times.
// Frame samples pass through combinationally; everything else is discarded.
// Ports: clk, reset (sync, active-high); set_stb/set_addr/set_data settings bus;
//        axis (stream interface, slave view); busy (not idle);
//        frame_cnt (frames completed since the last accepted trigger).
module ofdm_cp_framer
  import ofdm_framer_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SR_BASE = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   set_stb,
  input  logic [7:0]             set_addr,
  input  logic [31:0]            set_data,
  ofdm_cp_framer_if.slave        axis,
  output logic                   busy,
  output logic [15:0]            frame_cnt
);

  // Shadow settings, written from the bus at any time.
  logic [15:0] sh_flen, sh_gap, sh_off, sh_max;

  setting_reg #(
    .Width  (16),
    .MyAddr (8'(SR_BASE + SR_FRAME_LEN)),
    .AtReset(RstFrameLen)
  ) u_sr_frame_len (
    .clk_i   (clk),
    .rst_i   (reset),
    .strobe_i(set_stb),
    .addr_i  (set_addr),
    .in_i    (set_data),
    .out_o   (sh_flen)
  );

  setting_reg #(
    .Width  (16),
    .MyAddr (8'(SR_BASE + SR_GAP_LEN)),
    .AtReset(RstGapLen)
  ) u_sr_gap_len (
    .clk_i   (clk),
    .rst_i   (reset),
    .strobe_i(set_stb),
    .addr_i  (set_addr),
    .in_i    (set_data),
    .out_o   (sh_gap)
  );

  setting_reg #(
    .Width  (16),
    .MyAddr (8'(SR_BASE + SR_OFFSET)),
    .AtReset(RstOffset)
  ) u_sr_offset (
    .clk_i   (clk),
    .rst_i   (reset),
    .strobe_i(set_stb),
    .addr_i  (set_addr),
    .in_i    (set_data),
    .out_o   (sh_off)
  );

  setting_reg #(
    .Width  (16),
    .MyAddr (8'(SR_BASE + SR_MAX_FRAMES)),
    .AtReset(RstMaxFrame)
  ) u_sr_max_frames (
    .clk_i   (clk),
    .rst_i   (reset),
    .strobe_i(set_stb),
    .addr_i  (set_addr),
    .in_i    (set_data),
    .out_o   (sh_max)
  );

  state_e      state_d, state_q;
  logic [15:0] cnt_d, cnt_q;      // position within the current offset/frame/gap
  logic [15:0] fcnt_d, fcnt_q;
  logic [15:0] flen_d, flen_q;    // working copies, frozen for a whole burst
  logic [15:0] gap_d, gap_q;
  logic [15:0] off_d, off_q;
  logic [15:0] max_d, max_q;
  logic [15:0] fcnt_inc;
  logic        in_ready, out_valid, out_last;

  assign fcnt_inc = (fcnt_q == 16'hFFFF) ? fcnt_q : fcnt_q + 16'd1;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    fcnt_d    = fcnt_q;
    flen_d    = flen_q;
    gap_d     = gap_q;
    off_d     = off_q;
    max_d     = max_q;
    in_ready  = 1'b1;
    out_valid = 1'b0;
    out_last  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (axis.i_tvalid && axis.i_ttrig && (sh_max != 16'd0)) begin
          flen_d  = (sh_flen == 16'd0) ? 16'd1 : sh_flen;
          gap_d   = sh_gap;
          off_d   = sh_off;
          max_d   = sh_max;
          fcnt_d  = 16'd0;
          cnt_d   = 16'd0;
          state_d = (sh_off == 16'd0) ? StFrame : StOffset;
        end
      end

      StOffset: begin
        if (axis.i_tvalid) begin
          if (cnt_q == off_q - 16'd1) begin
            cnt_d   = 16'd0;
            state_d = StFrame;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
      end

      StFrame: begin
        in_ready  = axis.o_tready;
        out_valid = axis.i_tvalid;
        out_last  = (cnt_q == flen_q - 16'd1);
        if (axis.i_tvalid && axis.o_tready) begin
          cnt_d = cnt_q + 16'd1;
          if (out_last) begin
            cnt_d  = 16'd0;
            fcnt_d = fcnt_inc;
            if (fcnt_inc == max_q) begin
              state_d = StIdle;
            end else if (gap_q != 16'd0) begin
              state_d = StGap;
            end
          end
        end
      end

      StGap: begin
        if (axis.i_tvalid) begin
          if (cnt_q == gap_q - 16'd1) begin
            cnt_d   = 16'd0;
            state_d = StFrame;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= 16'd0;
      fcnt_q  <= 16'd0;
      flen_q  <= RstFrameLen;
      gap_q   <= RstGapLen;
      off_q   <= RstOffset;
      max_q   <= RstMaxFrame;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fcnt_q  <= fcnt_d;
      flen_q  <= flen_d;
      gap_q   <= gap_d;
      off_q   <= off_d;
      max_q   <= max_d;
    end
  end

  logic [WIDTH-1:0] pass_data;
  assign pass_data     = axis.i_tdata;
  assign axis.o_tdata  = pass_data;
  assign axis.o_tvalid = out_valid;
  assign axis.o_tlast  = out_last;
  assign axis.i_tready = in_ready;

  assign busy      = (state_q != StIdle);
  assign frame_cnt = fcnt_q;

  // Frame boundaries come from frame_len, never from the upstream tlast.
  logic unused_tlast;
  assign unused_tlast = axis.i_tlast;

endmodule

// File: tb/tb_ofdm_cp_framer.sv
module tb_ofdm_cp_framer;

  logic        clk = 1'b0;
  logic        reset;
  logic        set_stb;
  logic [7:0]  set_addr;
  logic [31:0] set_data;
  logic        busy;
  logic [15:0] frame_cnt;

  always #5 clk = ~clk;

  ofdm_cp_framer_if #(.WIDTH(32)) axis ();

  ofdm_cp_framer #(
    .WIDTH  (32),
    .SR_BASE(16)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .set_stb  (set_stb),
    .set_addr (set_addr),
    .set_data (set_data),
    .axis     (axis),
    .busy     (busy),
    .frame_cnt(frame_cnt)
  );

  int          n_vec = 0;
  int          n_err = 0;
  bit          throttle = 1'b0;
  logic [32:0] in_q[$];    // accepted inputs {trig, data}
  logic [32:0] out_q[$];   // delivered outputs {last, data}
  logic [32:0] exp_q[$];
  int          busy_cycles = 0;
  int          in_base, out_base, busy_base;
  int          exp_fcnt;
  bit          exp_busy;

  // Downstream ready: always 1 unless throttling, then a fair coin per cycle.
  always begin
    axis.o_tready = throttle ? 1'($urandom_range(1, 0)) : 1'b1;
    @(posedge clk);
    #1;
  end

  // Passive monitor: handshakes are stable from the falling edge to the next rising edge.
  always @(negedge clk) begin
    if (!reset) begin
      if (axis.i_tvalid && axis.i_tready) in_q.push_back({axis.i_ttrig, axis.i_tdata});
      if (axis.o_tvalid && axis.o_tready) out_q.push_back({axis.o_tlast, axis.o_tdata});
      if (busy) busy_cycles++;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic seg_start();
    in_base   = in_q.size();
    out_base  = out_q.size();
    busy_base = busy_cycles;
  endtask

  task automatic wr(input int unsigned off, input int unsigned val);
    set_addr = 8'(16 + off);
    set_data = val;
    set_stb  = 1'b1;
    @(posedge clk);
    #1;
    set_stb  = 1'b0;
  endtask

  task automatic wr_all(input int fl, input int gl, input int off, input int mf);
    wr(0, fl);
    wr(1, gl);
    wr(2, off);
    wr(3, mf);
  endtask

  task automatic push(input logic [31:0] v, input logic trig);
    bit acc;
    int guard;
    if (throttle) begin
      while ($urandom_range(1, 0) == 0) begin
        axis.i_tvalid = 1'b0;
        @(posedge clk);
        #1;
      end
    end
    axis.i_tdata  = v;
    axis.i_ttrig  = trig;
    axis.i_tlast  = 1'($urandom_range(1, 0));
    axis.i_tvalid = 1'b1;
    acc   = 1'b0;
    guard = 0;
    while (!acc && guard < 200) begin
      @(negedge clk);
      acc = axis.i_tready;
      @(posedge clk);
      #1;
      guard++;
    end
    axis.i_tvalid = 1'b0;
    axis.i_ttrig  = 1'b0;
    if (!acc) chk("push_timeout", 64'(acc), 64'd1);
  endtask

  task automatic ramp(input int from, input int to, input int trig_a, input int trig_b);
    for (int v = from; v <= to; v++) push(32'(v), (v == trig_a) || (v == trig_b));
  endtask

  // Reference: each accepted sample's role follows from its distance to the trigger.
  task automatic run_model(input int fl, input int gl, input int off, input int mf);
    int t;
    int efl;
    int period;
    int p;
    int w;
    t      = -1;
    efl    = (fl == 0) ? 1 : fl;
    period = efl + gl;
    exp_q.delete();
    for (int i = in_base; i < in_q.size(); i++) begin
      logic [32:0] s;
      s = in_q[i];
      if (t < 0) begin
        if (s[32] && mf != 0) begin
          t        = i;
          exp_fcnt = 0;
        end
      end else if (i - t > off) begin
        p = i - t - off - 1;
        w = p % period;
        if (w < efl) begin
          exp_q.push_back({w == efl - 1, s[31:0]});
          if (w == efl - 1) begin
            exp_fcnt++;
            if (exp_fcnt == mf) t = -1;
          end
        end
      end
    end
    exp_busy = (t >= 0);
  endtask

  task automatic cmp_stream(input string tag);
    int n;
    int e0;
    n = out_q.size() - out_base;
    chk({tag, "_count"}, 64'(n), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < n; i++) begin
      e0 = n_err;
      chk({tag, "_sample"}, 64'(out_q[out_base + i]), 64'(exp_q[i]));
      if (n_err != e0) break;
    end
  endtask

  task automatic end_checks(input string tag);
    chk({tag, "_busy"}, 64'(busy), 64'(exp_busy));
    chk({tag, "_frame_cnt"}, 64'(frame_cnt), 64'(exp_fcnt));
  endtask

  initial begin
    int last;
    reset         = 1'b1;
    set_stb       = 1'b0;
    set_addr      = 8'd0;
    set_data      = 32'd0;
    axis.i_tdata  = 32'd0;
    axis.i_ttrig  = 1'b0;
    axis.i_tlast  = 1'b0;
    axis.i_tvalid = 1'b0;
    exp_fcnt      = 0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state.
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_o_tvalid", 64'(axis.o_tvalid), 64'd0);
    chk("rst_o_tlast", 64'(axis.o_tlast), 64'd0);
    chk("rst_i_tready", 64'(axis.i_tready), 64'd1);
    chk("rst_frame_cnt", 64'(frame_cnt), 64'd0);

    // Power-up settings 64/16/0/1.
    seg_start();
    ramp(0, 99, 0, -1);
    run_model(64, 16, 0, 1);
    cmp_stream("defaults");
    end_checks("defaults");
    chk("defaults_first", 64'(out_q[out_base]), {31'd0, 1'b0, 32'd1});

    // Long burst with offset.
    wr_all(64, 16, 29, 12);
    seg_start();
    ramp(0, 1000, 0, -1);
    run_model(64, 16, 29, 12);
    cmp_stream("burst");
    end_checks("burst");
    last = out_q.size() - 1;
    chk("burst_n", 64'(out_q.size() - out_base), 64'd768);
    chk("burst_first", 64'(out_q[out_base]), {31'd0, 1'b0, 32'd30});
    chk("burst_last", 64'(out_q[last]), {31'd0, 1'b1, 32'd973});

    // Back-to-back frames, no gap, no offset.
    wr_all(8, 0, 0, 3);
    seg_start();
    ramp(95, 140, 100, -1);
    run_model(8, 0, 0, 3);
    cmp_stream("nogap");
    end_checks("nogap");
    last = out_q.size() - 1;
    chk("nogap_first", 64'(out_q[out_base]), {31'd0, 1'b0, 32'd101});
    chk("nogap_last", 64'(out_q[last]), {31'd0, 1'b1, 32'd124});

    // Random throttling on both sides.
    wr_all(64, 16, 29, 12);
    throttle = 1'b1;
    seg_start();
    ramp(0, 1000, 0, -1);
    run_model(64, 16, 29, 12);
    cmp_stream("throttle");
    end_checks("throttle");
    chk("throttle_n", 64'(out_q.size() - out_base), 64'd768);
    throttle = 1'b0;

    // Retrigger and frame_len write mid-burst are ignored until the next trigger.
    wr_all(8, 4, 2, 5);
    seg_start();
    ramp(0, 24, 0, 20);
    wr(0, 5);
    ramp(25, 79, -1, -1);
    run_model(8, 4, 2, 5);
    cmp_stream("retrig");
    end_checks("retrig");
    seg_start();
    ramp(0, 60, 0, -1);
    run_model(5, 4, 2, 5);
    cmp_stream("newlen");
    end_checks("newlen");

    // Reset in the middle of the first frame.
    wr_all(64, 16, 29, 12);
    seg_start();
    ramp(0, 68, 0, -1);
    axis.i_tdata  = 32'd69;
    axis.i_tvalid = 1'b1;
    reset         = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_o_tvalid", 64'(axis.o_tvalid), 64'd0);
    chk("abort_frame_cnt", 64'(frame_cnt), 64'd0);
    axis.i_tvalid = 1'b0;
    run_model(64, 16, 29, 12);
    cmp_stream("abort_prefix");
    wr_all(64, 16, 29, 12);
    exp_fcnt = 0;
    seg_start();
    ramp(0, 1000, 0, -1);
    run_model(64, 16, 29, 12);
    cmp_stream("restart");
    end_checks("restart");

    // max_frames = 0 disables triggering.
    wr(3, 0);
    seg_start();
    ramp(0, 50, 0, 10);
    run_model(64, 16, 29, 0);
    cmp_stream("maxzero");
    end_checks("maxzero");
    chk("maxzero_busy_cycles", 64'(busy_cycles - busy_base), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
